fft_sample_loader: RTL and testbench
====================================

Name: fft_sample_loader

Overview:
- Front end of the 32-point FFT datapath.
- Collects a serial stream of signed real samples into a 32-entry frame and presents that frame as a parallel bus to the first FFT stage's a0..a31 sample inputs.
- Double-buffered: one bank fills from the stream while the other bank holds a complete frame stable until downstream acknowledges it.

Parameters:
- P_SAMPLE_BITS, 9, width of one signed real sample; matches the stage-1 input width.
- P_POINTS, 32, frame length; fixed at 32 for this design; index width is 5.

Ports:
- CLK  input  1  clock; all logic rising-edge.
- RST  input  1  reset; asynchronous, active-high.
- i_sample  input  P_SAMPLE_BITS  signed sample from upstream.
- i_valid  input  1  i_sample is valid this cycle.
- i_sync  input  1  start-of-frame marker; qualified by i_valid.
- o_ready  output  1  loader can accept a sample this cycle.
- o_frame  output  P_POINTS*P_SAMPLE_BITS  output frame; sample k at bits [k*P_SAMPLE_BITS +: P_SAMPLE_BITS]; connects to a_k.
- o_frame_valid  output  1  o_frame holds a complete, stable frame.
- i_frame_ack  input  1  downstream has captured o_frame; 1-cycle pulse.
- o_sync_err  output  1  1-cycle pulse when i_sync truncates a partial frame.
- o_frame_cnt  output  16  count of frames delivered; wraps at 2^16.

Behaviour:
- Reset (async, immediate) values:
  - Write index 0; fill FSM in FILL; o_ready=1.
  - o_frame=0; o_frame_valid=0; o_sync_err=0; o_frame_cnt=0.
  - Any partial frame is discarded.
- Accept: a sample is accepted on a rising edge where i_valid && o_ready. The accepted sample is written to fill-bank slot[idx], then idx increments.
- i_sync on an accepted sample:
  - The sample is written to slot 0 and idx becomes 1.
  - If idx was nonzero, o_sync_err pulses the next cycle.
  - i_sync with idx==0 is not an error.
- Fill FSM:
  - FILL: o_ready=1. On acceptance of the sample at idx 31, the fill bank is full; go to TRANSFER logic.
  - WAIT: fill bank full, output bank occupied; o_ready=0; no writes.
  - Transfer condition: fill bank full AND (o_frame_valid==0 OR i_frame_ack==1) in the same cycle.
  - On transfer: the fill bank is copied to o_frame on that edge; o_frame_valid=1; o_frame_cnt++; idx=0; state returns to FILL.
  - If full without the transfer condition, enter WAIT and retry every cycle.
- Latency: o_frame_valid rises on the edge that accepts slot 31 when the output bank is free; the frame is visible in the following cycle. From WAIT, transfer occurs on the first edge where i_frame_ack=1; o_ready is back to 1 the cycle after.
- Output side:
  - o_frame is held bit-stable while o_frame_valid=1.
  - i_frame_ack while valid with no transfer in that cycle: o_frame_valid clears next cycle; o_frame keeps its last value.
  - i_frame_ack while o_frame_valid=0 is ignored.
- Simultaneous ack and completion: the new frame replaces the old one on the same edge. o_frame_valid stays 1 with no bubble, and o_frame_cnt increments once.
- Throughput: one sample per cycle sustained when ack arrives within 32 cycles of frame valid.
- No arithmetic is performed: samples pass through bit-exact, sign untouched. Imaginary-part zero padding belongs to the stage, not the loader.

Optional Feature:
- FFT_LOADER_BITREV_EN
  - Defined: accepted sample n is written to slot bitrev5(n), giving a bit-reversed frame for decimation-in-time ordering. i_sync/idx semantics are unchanged; slot 0 maps to 0.
  - Undefined: natural order, with sample n in slot n.

Test Plan:
- Reset, then stream samples 0..31 with values -16..15 and i_sync on the first: o_frame slot k = k-16; o_frame_valid=1 one cycle after the 32nd accept; o_frame_cnt=1.
- Continuous stream of 3 frames with i_frame_ack held low: after frame 2 fills, o_ready=0 and frame 1 stays stable. Pulse ack → frame 2 appears the same edge; o_ready=1 next cycle; o_frame_cnt=2.
- Ack in the same cycle as the 32nd sample of the next frame: o_frame_valid never drops; o_frame changes to the new frame; count increments by exactly 1.
- After 10 samples, assert i_sync with value 100: o_sync_err pulses once; the frame completes after 31 more samples with slot 0 = 100.
- Assert RST mid-frame after 20 samples and while o_frame_valid=1: all outputs return to reset values immediately; the next 32 samples form a clean frame.
- With FFT_LOADER_BITREV_EN, input samples n=0..31 with value n: slot 1 = 16, slot 2 = 8, slot 31 = 31.

Source files
------------

// File: rtl/fft_sample_loader.sv
// Double-buffered 32-sample frame loader for the FFT front end (optional macro FFT_LOADER_BITREV_EN selects bit-reversed slot order).
// Frame valid the cycle after slot 31 is accepted; o_ready drops while a full fill bank waits for i_frame_ack.
module fft_sample_loader #(
  parameter int P_SAMPLE_BITS = 9,
  parameter int P_POINTS      = 32
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic signed [P_SAMPLE_BITS-1:0]   i_sample,
  input  logic                              i_valid,
  input  logic                              i_sync,
  output logic                              o_ready,
  output logic [P_POINTS*P_SAMPLE_BITS-1:0] o_frame,
  output logic                              o_frame_valid,
  input  logic                              i_frame_ack,
  output logic                              o_sync_err,
  output logic [15:0]                       o_frame_cnt
);

  localparam int W = P_SAMPLE_BITS;

  typedef enum logic {S_FILL, S_WAIT} state_t;

  state_t                  state, state_nxt;
  logic [4:0]              idx;
  logic [4:0]              wr_idx;
  logic [4:0]              wr_slot;
  logic [W-1:0]            bank [P_POINTS];
  logic [P_POINTS*W-1:0]   fill_next;
  logic                    accept;
  logic                    last;
  logic                    xfer;

  assign accept = i_valid && o_ready;
  assign wr_idx = i_sync ? 5'd0 : idx;

`ifdef FFT_LOADER_BITREV_EN
  assign wr_slot = {wr_idx[0], wr_idx[1], wr_idx[2], wr_idx[3], wr_idx[4]};
`else
  assign wr_slot = wr_idx;
`endif

  // A sync sample restarts the frame, so it can never complete one.
  assign last = accept && !i_sync && (idx == 5'd31);
  assign xfer = (last || (state == S_WAIT)) && (!o_frame_valid || i_frame_ack);

  // Fill bank as it will look after this edge's write, so a completing frame transfers in one step.
  always_comb begin
    for (int k = 0; k < P_POINTS; k++) begin
      fill_next[k*W +: W] = (accept && (wr_slot == 5'(k))) ? i_sample : bank[k];
    end
  end

  always_comb begin
    state_nxt = state;
    o_ready   = (state == S_FILL);
    case (state)
      S_FILL: if (last && !xfer) state_nxt = S_WAIT;
      S_WAIT: if (xfer)          state_nxt = S_FILL;
      default:                   state_nxt = S_FILL;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= S_FILL;
    else     state <= state_nxt;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      idx           <= 5'd0;
      o_frame       <= '0;
      o_frame_valid <= 1'b0;
      o_sync_err    <= 1'b0;
      o_frame_cnt   <= 16'd0;
      for (int k = 0; k < P_POINTS; k++) bank[k] <= '0;
    end else begin
      o_sync_err <= accept && i_sync && (idx != 5'd0);
      if (accept) begin
        bank[wr_slot] <= i_sample;
        // Index 31 wraps to 0, which is where the next frame starts.
        idx <= i_sync ? 5'd1 : idx + 5'd1;
      end
      if (xfer) begin
        o_frame       <= fill_next;
        o_frame_valid <= 1'b1;
        o_frame_cnt   <= o_frame_cnt + 16'd1;
      end else if (i_frame_ack) begin
        o_frame_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fft_sample_loader.sv
// Directed bench for fft_sample_loader: fill, backpressure, ack/complete overlap, sync truncation, reset.
module tb_fft_sample_loader;

  logic               CLK = 1'b0;
  logic               RST;
  logic signed [8:0]  i_sample;
  logic               i_valid;
  logic               i_sync;
  logic               o_ready;
  logic [287:0]       o_frame;
  logic               o_frame_valid;
  logic               i_frame_ack;
  logic               o_sync_err;
  logic [15:0]        o_frame_cnt;

  int n_chk  = 0;
  int n_pass = 0;
  logic signed [8:0] sent [32];
  logic [287:0]      exp_a;
  int                drops;

  fft_sample_loader dut (
    .CLK(CLK), .RST(RST), .i_sample(i_sample), .i_valid(i_valid), .i_sync(i_sync),
    .o_ready(o_ready), .o_frame(o_frame), .o_frame_valid(o_frame_valid),
    .i_frame_ack(i_frame_ack), .o_sync_err(o_sync_err), .o_frame_cnt(o_frame_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [287:0] got, input logic [287:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  function automatic int slot_src(input int k);
    logic [4:0] b;
    b = k[4:0];
`ifdef FFT_LOADER_BITREV_EN
    return int'({b[0], b[1], b[2], b[3], b[4]});
`else
    return int'(b);
`endif
  endfunction

  function automatic logic [287:0] exp_frame();
    logic [287:0] r;
    for (int k = 0; k < 32; k++) r[k*9 +: 9] = sent[slot_src(k)];
    return r;
  endfunction

  // Called at a falling edge; returns at the next falling edge.
  task automatic push(input logic [8:0] v, input logic s, input logic ack);
    i_sample    = v;
    i_valid     = 1'b1;
    i_sync      = s;
    i_frame_ack = ack;
    @(negedge CLK);
    i_valid     = 1'b0;
    i_sync      = 1'b0;
    i_frame_ack = 1'b0;
  endtask

  task automatic push_frame(input int base, input int step, input logic ack_last);
    for (int k = 0; k < 32; k++) begin
      sent[k] = 9'(base + step * k);
      push(sent[k], k == 0, ack_last && (k == 31));
    end
  endtask

  task automatic ack_pulse();
    i_frame_ack = 1'b1;
    @(negedge CLK);
    i_frame_ack = 1'b0;
  endtask

  initial begin
    RST = 1'b1; i_sample = '0; i_valid = 1'b0; i_sync = 1'b0; i_frame_ack = 1'b0;
    @(negedge CLK);
    check("rst_ready", o_ready, 1);
    check("rst_valid", o_frame_valid, 0);
    check("rst_cnt",   o_frame_cnt, 0);
    check("rst_frame", o_frame, 0);
    RST = 1'b0;
    @(negedge CLK);

    // Frame 1: values -16..15
    for (int k = 0; k < 32; k++) sent[k] = 9'(k - 16);
    for (int k = 0; k < 31; k++) push(sent[k], k == 0, 1'b0);
    check("f1_not_yet_valid", o_frame_valid, 0);
    push(sent[31], 1'b0, 1'b0);
    check("f1_valid", o_frame_valid, 1);
    check("f1_frame", o_frame, exp_frame());
    check("f1_cnt",   o_frame_cnt, 1);
    exp_a = exp_frame();

    // Frame 2 fills while frame 1 is unacknowledged
    push_frame(0, 3, 1'b0);
    check("f2_wait_ready", o_ready, 0);
    check("f2_f1_held", o_frame, exp_a);
    repeat (3) @(negedge CLK);
    check("f2_f1_stable", o_frame, exp_a);
    check("f2_cnt_hold", o_frame_cnt, 1);
    ack_pulse();
    check("f2_frame", o_frame, exp_frame());
    check("f2_valid", o_frame_valid, 1);
    check("f2_ready", o_ready, 1);
    check("f2_cnt",   o_frame_cnt, 2);

    // Frame 3 completes on the same edge as the ack of frame 2
    drops = 0;
    for (int k = 0; k < 32; k++) begin
      sent[k] = 9'(-200 + 5 * k);
      push(sent[k], k == 0, k == 31);
      if (!o_frame_valid) drops++;
    end
    check("f3_no_bubble", drops, 0);
    check("f3_frame", o_frame, exp_frame());
    check("f3_cnt",   o_frame_cnt, 3);
    exp_a = exp_frame();

    // Plain ack clears valid but keeps the data
    ack_pulse();
    check("ack_clears_valid", o_frame_valid, 0);
    check("ack_keeps_frame", o_frame, exp_a);
    ack_pulse();
    check("ack_idle_ignored", o_frame_valid, 0);
    check("ack_idle_cnt", o_frame_cnt, 3);

    // Sync truncates after 10 samples
    for (int k = 0; k < 10; k++) push(9'(k + 1), k == 0, 1'b0);
    check("sync_no_err_first", o_sync_err, 0);
    sent[0] = 9'sd100;
    push(sent[0], 1'b1, 1'b0);
    check("sync_err_pulse", o_sync_err, 1);
    for (int k = 1; k < 32; k++) begin
      sent[k] = 9'(-2 * k);
      push(sent[k], 1'b0, 1'b0);
      if (k == 1) check("sync_err_once", o_sync_err, 0);
    end
    check("sync_valid", o_frame_valid, 1);
    check("sync_slot0", o_frame[8:0], 9'sd100);
    check("sync_frame", o_frame, exp_frame());
    check("sync_cnt", o_frame_cnt, 4);

    // Reset mid-frame while a frame is valid
    for (int k = 0; k < 20; k++) push(9'(k), k == 0, 1'b0);
    #2 RST = 1'b1;
    #1;
    check("mid_rst_valid", o_frame_valid, 0);
    check("mid_rst_frame", o_frame, 0);
    check("mid_rst_cnt",   o_frame_cnt, 0);
    check("mid_rst_ready", o_ready, 1);
    @(negedge CLK);
    RST = 1'b0;
    push_frame(-100, 7, 1'b0);
    check("post_rst_frame", o_frame, exp_frame());
    check("post_rst_cnt",   o_frame_cnt, 1);

    // Sample n has value n: slot placement depends on ordering mode
    ack_pulse();
    push_frame(0, 1, 1'b0);
`ifdef FFT_LOADER_BITREV_EN
    check("order_slot1",  o_frame[9 +: 9],   9'd16);
    check("order_slot2",  o_frame[18 +: 9],  9'd8);
`else
    check("order_slot1",  o_frame[9 +: 9],   9'd1);
    check("order_slot2",  o_frame[18 +: 9],  9'd2);
`endif
    check("order_slot31", o_frame[279 +: 9], 9'd31);
    check("order_cnt", o_frame_cnt, 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
